// File: rtl/mix_load_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mix_load_seq
//  Purpose  : Sequences a possibly unaligned 32-bit load into one or two
//             word-aligned memory reads. It then merges the two little-endian
//             words into a single result word.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        in   clock, rising edge
//    rst_ni       in   asynchronous active-low reset
//    flush_i      in   abandon the current operation
//    valid_i      in   load request valid
//    ready_o      out  block can accept a request (IDLE only)
//    addr_i       in   byte address (may be unaligned)
//    trans_id_i   in   request tag
//    req_o        out  memory read request
//    gnt_i        in   grant of req_o
//    req_addr_o   out  word-aligned read address
//    rvalid_i     in   read data valid
//    rdata_i      in   read data, little-endian
//    valid_o      out  merged result valid
//    ready_i      in   consumer accepts the result
//    result_o     out  merged 32-bit word
//    trans_id_o   out  tag of the result
// ============================================================================
module mix_load_seq #(
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  // request side
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [31:0]              addr_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  // memory side
  output logic                     req_o,
  input  logic                     gnt_i,
  output logic [31:0]              req_addr_o,
  input  logic                     rvalid_i,
  input  logic [31:0]              rdata_i,
  // result side
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [31:0]              result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ_LO  = 3'd1;
  localparam logic [2:0] WAIT_LO = 3'd2;
  localparam logic [2:0] REQ_HI  = 3'd3;
  localparam logic [2:0] WAIT_HI = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] DRAIN   = 3'd6;

  logic [2:0]               state_q, state_d;

  // Datapath registers
  logic [29:0]              word_q;      // word index of the lo read
  logic [1:0]               off_q;       // byte offset inside the lo word
  logic [TRANS_ID_BITS-1:0] tid_q;
  logic [31:0]              lo_q;
  logic [31:0]              result_q, result_d;

  logic                     accept;
  logic                     lo_take;
  logic                     hi_take;
  logic [31:0]              lo_addr;
  logic [31:0]              hi_addr;

  // A flush in IDLE keeps the FSM in IDLE, so a request offered in that
  // cycle is not taken even though ready_o is high.
  assign accept  = (state_q == IDLE) && valid_i && !flush_i;

  // Read data is only kept when no flush arrives with it; a flushed beat is
  // consumed and thrown away.
  assign lo_take = (state_q == WAIT_LO) && rvalid_i && !flush_i;
  assign hi_take = (state_q == WAIT_HI) && rvalid_i && !flush_i;

  // The 30-bit word increment wraps 0xFFFFFFFC to 0x00000000 by itself.
  assign lo_addr = {word_q, 2'b00};
  assign hi_addr = {word_q + 30'd1, 2'b00};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic (flush outranks gnt, rvalid and ready)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = REQ_LO;
      end
      REQ_LO: begin
        if (flush_i)    state_d = IDLE;
        else if (gnt_i) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (rvalid_i) begin
          if (flush_i)           state_d = IDLE;
          else if (off_q == 2'd0) state_d = DONE;
          else                   state_d = REQ_HI;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      REQ_HI: begin
        if (flush_i)    state_d = IDLE;
        else if (gnt_i) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (rvalid_i) begin
          if (flush_i) state_d = IDLE;
          else         state_d = DONE;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (flush_i || ready_i) state_d = IDLE;
      end
      DRAIN: begin
        // The outstanding read must return before the memory side is free.
        if (rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (all are decoded from the registered state)
  // --------------------------------------------------------------------------
  always_comb begin
    ready_o    = 1'b0;
    req_o      = 1'b0;
    req_addr_o = 32'h0;
    valid_o    = 1'b0;
    unique case (state_q)
      IDLE:   ready_o = 1'b1;
      REQ_LO: begin
        req_o      = 1'b1;
        req_addr_o = lo_addr;
      end
      REQ_HI: begin
        req_o      = 1'b1;
        req_addr_o = hi_addr;
      end
      DONE:    valid_o = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Result merge. Bytes off..3 of lo form the low part of the result and
  // bytes 0..off-1 of hi fill the top. This is the same as
  // (lo >> 8*off) | (hi << 8*(4-off)), written as concatenations.
  // --------------------------------------------------------------------------
  always_comb begin
    result_d = result_q;
    if (lo_take && (off_q == 2'd0)) begin
      result_d = rdata_i;
    end else if (hi_take) begin
      unique case (off_q)
        2'd1:    result_d = {rdata_i[7:0],  lo_q[31:8]};
        2'd2:    result_d = {rdata_i[15:0], lo_q[31:16]};
        2'd3:    result_d = {rdata_i[23:0], lo_q[31:24]};
        default: result_d = lo_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q   <= '0;
      off_q    <= '0;
      tid_q    <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        word_q <= addr_i[31:2];
        off_q  <= addr_i[1:0];
        tid_q  <= trans_id_i;
      end
      if (lo_take) begin
        lo_q <= rdata_i;
      end
      result_q <= result_d;
    end
  end

  // The tag and result registers hold their values for the whole DONE phase.
  assign result_o   = result_q;
  assign trans_id_o = tid_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_load_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mix_load_seq
//  Purpose  : Self-checking bench for mix_load_seq. It applies a table of
//             directed loads, then runs hand-written stall, flush and
//             reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mix_load_seq;

  localparam int TRANS_ID_BITS = 3;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic                     flush_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [31:0]              addr_i;
  logic [TRANS_ID_BITS-1:0] trans_id_i;
  logic                     req_o;
  logic                     gnt_i;
  logic [31:0]              req_addr_o;
  logic                     rvalid_i;
  logic [31:0]              rdata_i;
  logic                     valid_o;
  logic                     ready_i;
  logic [31:0]              result_o;
  logic [TRANS_ID_BITS-1:0] trans_id_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  mix_load_seq #(.TRANS_ID_BITS(TRANS_ID_BITS)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .addr_i     (addr_i),
    .trans_id_i (trans_id_i),
    .req_o      (req_o),
    .gnt_i      (gnt_i),
    .req_addr_o (req_addr_o),
    .rvalid_i   (rvalid_i),
    .rdata_i    (rdata_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .trans_id_o (trans_id_o)
  );

  typedef struct {
    logic [31:0]              addr;
    logic [TRANS_ID_BITS-1:0] tid;
    logic [31:0]              lo;
    logic [31:0]              hi;
    logic                     aligned;
    logic [31:0]              exp_lo_addr;
    logic [31:0]              exp_hi_addr;
    logic [31:0]              exp_result;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Outputs are decoded from registered state, so they are checked and the
  // inputs are changed on the falling edge.
  task automatic tick();
    @(negedge clk_i);
  endtask

  // Full load with gnt in the same cycle as req and rvalid one cycle later.
  task automatic run_load(input vec_t v);
    tick();
    check("idle ready_o", {31'd0, ready_o}, 32'd1);
    valid_i    = 1'b1;
    addr_i     = v.addr;
    trans_id_i = v.tid;
    tick();                                   // REQ_LO
    valid_i = 1'b0;
    addr_i  = 32'h0;
    check("lo req_o", {31'd0, req_o}, 32'd1);
    check("lo req_addr_o", req_addr_o, v.exp_lo_addr);
    check("lo ready_o", {31'd0, ready_o}, 32'd0);
    gnt_i = 1'b1;
    tick();                                   // WAIT_LO
    gnt_i = 1'b0;
    check("wait_lo req_o", {31'd0, req_o}, 32'd0);
    rvalid_i = 1'b1;
    rdata_i  = v.lo;
    tick();
    rvalid_i = 1'b0;
    rdata_i  = 32'h0;
    if (!v.aligned) begin                     // REQ_HI
      check("hi req_o", {31'd0, req_o}, 32'd1);
      check("hi req_addr_o", req_addr_o, v.exp_hi_addr);
      check("hi valid_o early", {31'd0, valid_o}, 32'd0);
      gnt_i = 1'b1;
      tick();                                 // WAIT_HI
      gnt_i    = 1'b0;
      rvalid_i = 1'b1;
      rdata_i  = v.hi;
      tick();
      rvalid_i = 1'b0;
      rdata_i  = 32'h0;
    end
    check("done valid_o", {31'd0, valid_o}, 32'd1);
    check("done result_o", result_o, v.exp_result);
    check("done trans_id_o", {29'd0, trans_id_o}, {29'd0, v.tid});
    check("done req_o", {31'd0, req_o}, 32'd0);
    ready_i = 1'b1;
    tick();                                   // back to IDLE
    ready_i = 1'b0;
    check("after valid_o", {31'd0, valid_o}, 32'd0);
    check("after ready_o", {31'd0, ready_o}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h0000_1000, 3'd2, 32'hDDCC_BBAA, 32'h0,         1'b1, 32'h0000_1000, 32'h0,         32'hDDCC_BBAA};
    vecs[1] = '{32'h0000_1001, 3'd3, 32'h4433_2211, 32'h8877_6655, 1'b0, 32'h0000_1000, 32'h0000_1004, 32'h5544_3322};
    vecs[2] = '{32'hFFFF_FFFF, 3'd7, 32'h4433_2211, 32'h8877_6655, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h7766_5544};
    vecs[3] = '{32'h0000_2006, 3'd4, 32'h4433_2211, 32'h8877_6655, 1'b0, 32'h0000_2004, 32'h0000_2008, 32'h6655_4433};
    vecs[4] = '{32'hFFFF_FFFC, 3'd1, 32'h1234_5678, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0,         32'h1234_5678};
    vecs[5] = '{32'h0000_0003, 3'd6, 32'hCAFE_BABE, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'hADBE_EFCA};

    rst_ni     = 1'b0;
    flush_i    = 1'b0;
    valid_i    = 1'b0;
    addr_i     = 32'h0;
    trans_id_i = '0;
    gnt_i      = 1'b0;
    rvalid_i   = 1'b0;
    rdata_i    = 32'h0;
    ready_i    = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst ready_o", {31'd0, ready_o}, 32'd1);
    check("rst req_o", {31'd0, req_o}, 32'd0);
    check("rst valid_o", {31'd0, valid_o}, 32'd0);
    check("rst req_addr_o", req_addr_o, 32'h0);
    check("rst result_o", result_o, 32'h0);
    check("rst trans_id_o", {29'd0, trans_id_o}, 32'd0);
    rst_ni = 1'b1;

    // ---------------- table-driven loads ----------------
    for (int i = 0; i < 6; i++) begin
      run_load(vecs[i]);
    end

    // ---------------- rvalid in IDLE is ignored ----------------
    tick();
    rvalid_i = 1'b1;
    rdata_i  = 32'hFFFF_FFFF;
    tick();
    rvalid_i = 1'b0;
    rdata_i  = 32'h0;
    check("idle rvalid ready_o", {31'd0, ready_o}, 32'd1);
    check("idle rvalid valid_o", {31'd0, valid_o}, 32'd0);
    check("idle rvalid result_o", result_o, 32'hADBE_EFCA);

    // ---------------- stalls: gnt low 3 cycles, ready low 4 cycles ----------
    // addr 0x2002 (off 2): {hi[15:0], lo[31:16]} = 0x3344AABB
    valid_i    = 1'b1;
    addr_i     = 32'h0000_2002;
    trans_id_i = 3'd5;
    tick();
    valid_i = 1'b0;
    addr_i  = 32'h0;
    for (int c = 0; c < 3; c++) begin
      check("stall req_o", {31'd0, req_o}, 32'd1);
      check("stall req_addr_o", req_addr_o, 32'h0000_2000);
      tick();
    end
    check("stall req_o at gnt", {31'd0, req_o}, 32'd1);
    gnt_i = 1'b1;
    tick();
    gnt_i    = 1'b0;
    rvalid_i = 1'b1;
    rdata_i  = 32'hAABB_CCDD;
    tick();
    rvalid_i = 1'b0;
    check("stall hi req_addr_o", req_addr_o, 32'h0000_2004);
    gnt_i = 1'b1;
    tick();
    gnt_i    = 1'b0;
    rvalid_i = 1'b1;
    rdata_i  = 32'h1122_3344;
    tick();
    rvalid_i = 1'b0;
    rdata_i  = 32'h0;
    for (int c = 0; c < 4; c++) begin
      check("stall valid_o", {31'd0, valid_o}, 32'd1);
      check("stall result_o", result_o, 32'h3344_AABB);
      check("stall trans_id_o", {29'd0, trans_id_o}, 32'd5);
      tick();
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("stall single result", {31'd0, valid_o}, 32'd0);

    // ---------------- flush in WAIT_HI, rvalid two cycles later -------------
    valid_i    = 1'b1;
    addr_i     = 32'h0000_3001;
    trans_id_i = 3'd1;
    tick();
    valid_i = 1'b0;
    gnt_i   = 1'b1;
    tick();
    gnt_i    = 1'b0;
    rvalid_i = 1'b1;
    rdata_i  = 32'h0102_0304;
    tick();
    rvalid_i = 1'b0;
    gnt_i    = 1'b1;
    tick();                                   // WAIT_HI
    gnt_i   = 1'b0;
    flush_i = 1'b1;
    tick();                                   // DRAIN
    flush_i = 1'b0;
    check("drain ready_o", {31'd0, ready_o}, 32'd0);
    check("drain req_o", {31'd0, req_o}, 32'd0);
    check("drain valid_o", {31'd0, valid_o}, 32'd0);
    tick();
    check("drain hold ready_o", {31'd0, ready_o}, 32'd0);
    rvalid_i = 1'b1;
    rdata_i  = 32'hBAD0_BAD0;
    tick();
    rvalid_i = 1'b0;
    rdata_i  = 32'h0;
    check("post drain ready_o", {31'd0, ready_o}, 32'd1);
    check("post drain valid_o", {31'd0, valid_o}, 32'd0);
    run_load(vecs[1]);

    // ---------------- reset while in REQ_HI ----------------
    valid_i    = 1'b1;
    addr_i     = 32'h0000_4003;
    trans_id_i = 3'd6;
    tick();
    valid_i = 1'b0;
    gnt_i   = 1'b1;
    tick();
    gnt_i    = 1'b0;
    rvalid_i = 1'b1;
    rdata_i  = 32'h5566_7788;
    tick();
    rvalid_i = 1'b0;
    check("pre-rst hi req_o", {31'd0, req_o}, 32'd1);
    check("pre-rst hi req_addr_o", req_addr_o, 32'h0000_4004);
    rst_ni = 1'b0;
    #1;
    check("mid rst req_o", {31'd0, req_o}, 32'd0);
    check("mid rst valid_o", {31'd0, valid_o}, 32'd0);
    check("mid rst ready_o", {31'd0, ready_o}, 32'd1);
    check("mid rst trans_id_o", {29'd0, trans_id_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    run_load(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mix_load_seq.md
MIX_LOAD_SEQ -- requirements
Module: mix_load_seq

Interface
REQ-001 Parameter TRANS_ID_BITS, default 3, width of the transaction tag carried with each request.
REQ-002 The block SHALL expose the following ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  pipeline flush; abandons the current operation.
- valid_i  in  1  load request valid.
- ready_o  out  1  block can accept a request.
- addr_i  in  32  byte address; may be unaligned.
- trans_id_i  in  TRANS_ID_BITS  tag of the request.
- req_o  out  1  memory read request.
- gnt_i  in  1  memory grant of req_o.
- req_addr_o  out  32  word-aligned read address.
- rvalid_i  in  1  read data valid.
- rdata_i  in  32  read data, little-endian.
- valid_o  out  1  merged result valid.
- ready_i  in  1  consumer accepts the result.
- result_o  out  32  merged 32-bit word.
- trans_id_o  out  TRANS_ID_BITS  tag of the result.

Function
REQ-003 The FSM SHALL use the states IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, DONE and DRAIN.
REQ-004 ready_o SHALL be 1 only in IDLE; a request is accepted when valid_i & ready_o at a clock edge.
REQ-005 On acceptance, the block SHALL register addr_i, off = addr_i[1:0] and trans_id_i, and go to REQ_LO.
REQ-006 The lo read address SHALL be {addr[31:2],2'b00}.
REQ-007 The hi read address SHALL be the lo address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-008 In REQ_LO and REQ_HI, the block SHALL assert req_o with the matching req_addr_o, held stable until gnt_i.
REQ-009 On gnt_i, the FSM SHALL go to WAIT_LO or WAIT_HI respectively.
REQ-010 req_o SHALL be 0 in all other states, and at most one read SHALL be outstanding.
REQ-011 In WAIT_LO, on rvalid_i the block SHALL capture lo = rdata_i, then go to DONE if off==0, else to REQ_HI.
REQ-012 In WAIT_HI, on rvalid_i the block SHALL capture hi = rdata_i and go to DONE.
REQ-013 The merged result SHALL be result = (lo >> 8*off) | (hi << 8*(4-off)) truncated to 32 bits; for off==0, result = lo and no hi read is issued.
REQ-014 In DONE, valid_o SHALL be 1, with result_o and trans_id_o registered and stable until ready_i.
REQ-015 On ready_i in DONE, the FSM SHALL return to IDLE; no new request is accepted in that same cycle.
REQ-016 Latency with gnt_i in the same cycle as req_o and rvalid_i one cycle after gnt_i:
- aligned: valid_o 3 cycles after acceptance;
- unaligned: valid_o 5 cycles after acceptance.
REQ-017 rvalid_i in IDLE, REQ_* or DONE SHALL be ignored.
REQ-018 A flush in IDLE, REQ_* or DONE SHALL take the FSM to IDLE next cycle, dropping valid_o and req_o; an ungranted request is withdrawn.
REQ-019 A flush in WAIT_LO or WAIT_HI SHALL take the FSM to DRAIN.
REQ-020 A flush in WAIT_* coincident with rvalid_i SHALL consume that data and go straight to IDLE.
REQ-021 In DRAIN, ready_o, req_o and valid_o SHALL be 0; the returned data SHALL be discarded on rvalid_i, then the FSM goes to IDLE.
REQ-022 flush_i SHALL take priority over gnt_i, rvalid_i and ready_i in the same cycle.
REQ-023 valid_o SHALL never assert for a flushed transaction.

Reset
REQ-024 While rst_ni is 0, the FSM SHALL be in IDLE with ready_o=1; all other outputs and internal registers 0.
REQ-025 Reset mid-operation SHALL abandon the operation without draining; the memory side is reset together with the block.

Verification
REQ-026 Aligned load: addr 0x1000, tag 2, rdata 0xDDCCBBAA -> one req at 0x1000; result 0xDDCCBBAA, tag 2, after 3 cycles.
REQ-027 Unaligned load, off=1: addr 0x1001, lo 0x44332211, hi 0x88776655 -> reqs at 0x1000 then 0x1004; result 0x55443322.
REQ-028 Unaligned load, off=3, with wrap: addr 0xFFFFFFFF, lo 0x44332211, hi 0x88776655 -> hi req at 0x00000000; result 0x77665544.
REQ-029 Stalls: gnt_i held 0 for 3 cycles and ready_i held 0 for 4 cycles -> req_addr_o, result_o and trans_id_o stable throughout; single result.
REQ-030 Flush in WAIT_HI, rvalid_i 2 cycles later -> DRAIN, valid_o stays 0, ready_o=1 the cycle after rvalid_i; next request completes correctly.
REQ-031 rst_ni asserted in REQ_HI -> IDLE immediately; req_o=0, valid_o=0, ready_o=1.
